// File: rtl/vga_text_terminal_writer_if.sv
// rtl/vga_text_terminal_writer_if.sv - character stream and Avalon-MM bus bundle for the text terminal writer
interface vga_text_terminal_writer_if;
    logic        CHAR_VALID;
    logic [7:0]  CHAR_DATA;
    logic        CHAR_INV;
    logic        CHAR_READY;
    logic [9:0]  AVL_M_ADDR;
    logic        AVL_M_WRITE;
    logic        AVL_M_READ;
    logic [3:0]  AVL_M_BYTE_EN;
    logic [31:0] AVL_M_WRITEDATA;
    logic [31:0] AVL_M_READDATA;
    logic [6:0]  CURSOR_COL;
    logic [4:0]  CURSOR_ROW;
    logic        BUSY;

    // The writer side: consumes characters, masters the VRAM bus.
    modport master (
        input  CHAR_VALID, CHAR_DATA, CHAR_INV, AVL_M_READDATA,
        output CHAR_READY, AVL_M_ADDR, AVL_M_WRITE, AVL_M_READ, AVL_M_BYTE_EN,
               AVL_M_WRITEDATA, CURSOR_COL, CURSOR_ROW, BUSY
    );

    // The environment side: character source plus VRAM slave.
    modport slave (
        output CHAR_VALID, CHAR_DATA, CHAR_INV, AVL_M_READDATA,
        input  CHAR_READY, AVL_M_ADDR, AVL_M_WRITE, AVL_M_READ, AVL_M_BYTE_EN,
               AVL_M_WRITEDATA, CURSOR_COL, CURSOR_ROW, BUSY
    );
endinterface

// File: rtl/vga_text_terminal_writer.sv
// rtl/vga_text_terminal_writer.sv - character stream to VGA text VRAM writer with cursor, scroll and clear
module vga_text_terminal_writer #(
    parameter int COLS = 80,
    parameter int ROWS = 30
) (
    input  logic                          CLK,
    input  logic                          RESET,
    vga_text_terminal_writer_if.master    bus
);

    localparam int W         = COLS / 4;
    localparam int WORDS     = COLS * ROWS / 4;
    localparam int SCR_WORDS = (ROWS - 1) * W;

    localparam logic [11:0] COLS_12     = 12'(COLS);
    localparam logic [6:0]  COL_LAST    = 7'(COLS - 1);
    localparam logic [4:0]  ROW_LAST    = 5'(ROWS - 1);
    localparam logic [9:0]  W_10        = 10'(W);
    localparam logic [9:0]  SCR_LAST    = 10'(SCR_WORDS - 1);
    localparam logic [9:0]  CLR_SCR_BEG = 10'(SCR_WORDS);
    localparam logic [9:0]  WORD_LAST   = 10'(WORDS - 1);

    localparam logic [7:0] CH_BS = 8'h08;
    localparam logic [7:0] CH_LF = 8'h0A;
    localparam logic [7:0] CH_FF = 8'h0C;
    localparam logic [7:0] CH_CR = 8'h0D;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        PUT     = 3'd1,
        SCR_RD  = 3'd2,
        SCR_CAP = 3'd3,
        SCR_WR  = 3'd4,
        CLR     = 3'd5
    } state_t;

    state_t      state;
    logic [7:0]  char_q;
    logic [6:0]  col;
    logic [4:0]  row;
    logic        char_ready;
    logic [9:0]  avl_addr;
    logic        avl_write;
    logic        avl_read;
    logic [3:0]  avl_be;
    logic [31:0] avl_wdata;
    logic        busy;
    logic [9:0]  scr_idx;

    logic [11:0] idx;
    logic        in_printable;
    logic        q_printable;
    logic        put_adv;

    // Cell index of the cursor, printable classification and row-advance decision for PUT.
    always_comb begin
        idx          = row * COLS_12 + 12'(col);
        in_printable = !(bus.CHAR_DATA == CH_BS || bus.CHAR_DATA == CH_LF ||
                         bus.CHAR_DATA == CH_FF || bus.CHAR_DATA == CH_CR);
        q_printable  = !(char_q == CH_BS || char_q == CH_LF ||
                         char_q == CH_FF || char_q == CH_CR);
        put_adv      = (char_q == CH_LF) || (q_printable && col == COL_LAST);
    end

    // Main control FSM; every bus output and the cursor are registered here.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state      <= IDLE;
            char_q     <= 8'h00;
            col        <= 7'd0;
            row        <= 5'd0;
            char_ready <= 1'b0;
            avl_addr   <= 10'd0;
            avl_write  <= 1'b0;
            avl_read   <= 1'b0;
            avl_be     <= 4'd0;
            avl_wdata  <= 32'd0;
            busy       <= 1'b0;
            scr_idx    <= 10'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (!char_ready) begin
                        char_ready <= 1'b1;
                    end else if (bus.CHAR_VALID) begin
                        char_ready <= 1'b0;
                        char_q     <= bus.CHAR_DATA;
                        state      <= PUT;
                        if (in_printable) begin
                            avl_addr  <= idx[11:2];
                            avl_be    <= 4'b0001 << idx[1:0];
                            avl_wdata <= {4{bus.CHAR_INV, bus.CHAR_DATA[6:0]}};
                            avl_write <= 1'b1;
                        end
                    end
                end
                PUT: begin
                    avl_write <= 1'b0;
                    if (char_q == CH_FF) begin
                        state     <= CLR;
                        busy      <= 1'b1;
                        avl_addr  <= 10'd0;
                        avl_be    <= 4'hF;
                        avl_wdata <= 32'd0;
                        avl_write <= 1'b1;
                    end else begin
                        if (char_q == CH_CR || put_adv) begin
                            col <= 7'd0;
                        end else if (char_q == CH_BS) begin
                            if (col != 7'd0) begin
                                col <= col - 7'd1;
                            end
                        end else begin
                            col <= col + 7'd1;
                        end
                        if (put_adv && row == ROW_LAST) begin
                            state    <= SCR_RD;
                            busy     <= 1'b1;
                            scr_idx  <= 10'd0;
                            avl_addr <= W_10;
                            avl_read <= 1'b1;
                        end else begin
                            if (put_adv) begin
                                row <= row + 5'd1;
                            end
                            state      <= IDLE;
                            char_ready <= 1'b1;
                        end
                    end
                end
                SCR_RD: begin
                    avl_read <= 1'b0;
                    state    <= SCR_CAP;
                end
                SCR_CAP: begin
                    avl_wdata <= bus.AVL_M_READDATA;
                    avl_addr  <= scr_idx;
                    avl_be    <= 4'hF;
                    avl_write <= 1'b1;
                    state     <= SCR_WR;
                end
                SCR_WR: begin
                    if (scr_idx == SCR_LAST) begin
                        state     <= CLR;
                        avl_addr  <= CLR_SCR_BEG;
                        avl_wdata <= 32'd0;
                    end else begin
                        avl_write <= 1'b0;
                        avl_read  <= 1'b1;
                        avl_addr  <= scr_idx + W_10 + 10'd1;
                        scr_idx   <= scr_idx + 10'd1;
                        state     <= SCR_RD;
                    end
                end
                CLR: begin
                    if (avl_addr == WORD_LAST) begin
                        avl_write  <= 1'b0;
                        busy       <= 1'b0;
                        char_ready <= 1'b1;
                        state      <= IDLE;
                        if (char_q == CH_FF) begin
                            col <= 7'd0;
                            row <= 5'd0;
                        end
                    end else begin
                        avl_addr <= avl_addr + 10'd1;
                    end
                end
                default: begin
                    state     <= IDLE;
                    avl_write <= 1'b0;
                    avl_read  <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

    assign bus.CHAR_READY      = char_ready;
    assign bus.AVL_M_ADDR      = avl_addr;
    assign bus.AVL_M_WRITE     = avl_write;
    assign bus.AVL_M_READ      = avl_read;
    assign bus.AVL_M_BYTE_EN   = avl_be;
    assign bus.AVL_M_WRITEDATA = avl_wdata;
    assign bus.CURSOR_COL      = col;
    assign bus.CURSOR_ROW      = row;
    assign bus.BUSY            = busy;

endmodule

// File: tb/tb_vga_text_terminal_writer.sv
// tb/tb_vga_text_terminal_writer.sv - scoreboard bench for the VGA text terminal writer
module tb_vga_text_terminal_writer;

    logic CLK = 1'b0;
    logic RESET;
    bit   fill_req;

    always #10 CLK = ~CLK;

    vga_text_terminal_writer_if bus();

    vga_text_terminal_writer #(.COLS(80), .ROWS(30)) dut (
        .CLK   (CLK),
        .RESET (RESET),
        .bus   (bus)
    );

    typedef struct packed {
        logic        wr;
        logic [9:0]  addr;
        logic [3:0]  be;
        logic [31:0] data;
    } op_t;

    op_t         exp_q[$];
    int          checks = 0;
    int          errors = 0;
    bit   [31:0] mem    [0:599];
    logic [31:0] shadow [0:599];
    int          m_col;
    int          m_row;

    function automatic logic [31:0] pat(int k);
        return 32'(32'h9E3779B9 * (k + 1));
    endfunction

    // VRAM slave: byte-lane writes, one-cycle read latency, optional bulk pattern fill.
    always @(posedge CLK) begin
        if (fill_req) begin
            for (int k = 0; k < 600; k++) mem[k] <= pat(k);
        end else begin
            if (bus.AVL_M_WRITE && bus.AVL_M_ADDR < 10'd600) begin
                for (int b = 0; b < 4; b++)
                    if (bus.AVL_M_BYTE_EN[b]) mem[bus.AVL_M_ADDR][b*8 +: 8] <= bus.AVL_M_WRITEDATA[b*8 +: 8];
            end
            if (bus.AVL_M_READ && bus.AVL_M_ADDR < 10'd600)
                bus.AVL_M_READDATA <= mem[bus.AVL_M_ADDR];
        end
    end

    // Bus monitor: every strobe cycle is popped from the scoreboard and compared.
    always @(negedge CLK) begin
        if (!RESET && (bus.AVL_M_WRITE || bus.AVL_M_READ)) begin
            op_t o;
            op_t e;
            checks++;
            assert (!(bus.AVL_M_WRITE && bus.AVL_M_READ)) else begin
                errors++;
                $error("FAIL rd_wr_exclusive observed both high expected one");
            end
            checks++;
            assert (exp_q.size() !== 0) else begin
                errors++;
                $error("FAIL unexpected_access observed addr %0d wr %0b expected none", bus.AVL_M_ADDR, bus.AVL_M_WRITE);
            end
            if (exp_q.size() != 0) begin
                e      = exp_q.pop_front();
                o.wr   = bus.AVL_M_WRITE;
                o.addr = bus.AVL_M_ADDR;
                o.be   = bus.AVL_M_WRITE ? bus.AVL_M_BYTE_EN : 4'd0;
                o.data = bus.AVL_M_WRITE ? bus.AVL_M_WRITEDATA : 32'd0;
                checks++;
                assert (o === e) else begin
                    errors++;
                    $error("FAIL bus_op observed wr=%0b addr=%0d be=%b data=%h expected wr=%0b addr=%0d be=%b data=%h",
                           o.wr, o.addr, o.be, o.data, e.wr, e.addr, e.be, e.data);
                end
            end
        end
    end

    task automatic push(logic wr, int addr, logic [3:0] be, logic [31:0] d);
        op_t op;
        op.wr = wr; op.addr = 10'(addr); op.be = be; op.data = d;
        exp_q.push_back(op);
    endtask

    task automatic model_adv();
        if (m_row == 29) begin
            for (int i = 0; i < 580; i++) begin
                push(1'b0, i + 20, 4'd0, 32'd0);
                push(1'b1, i, 4'hF, shadow[i + 20]);
                shadow[i] = shadow[i + 20];
            end
            for (int i = 580; i < 600; i++) begin
                push(1'b1, i, 4'hF, 32'd0);
                shadow[i] = 32'd0;
            end
        end else begin
            m_row++;
        end
    endtask

    task automatic model_char(logic [7:0] c, logic inv);
        int          ix;
        logic [7:0]  g;
        logic [3:0]  be;
        case (c)
            8'h0D: m_col = 0;
            8'h0A: begin m_col = 0; model_adv(); end
            8'h08: if (m_col > 0) m_col--;
            8'h0C: begin
                for (int i = 0; i < 600; i++) begin
                    push(1'b1, i, 4'hF, 32'd0);
                    shadow[i] = 32'd0;
                end
                m_col = 0;
                m_row = 0;
            end
            default: begin
                ix = m_row * 80 + m_col;
                g  = {inv, c[6:0]};
                be = 4'b0001 << (ix % 4);
                push(1'b1, ix / 4, be, {4{g}});
                shadow[ix / 4][(ix % 4)*8 +: 8] = g;
                if (m_col == 79) begin m_col = 0; model_adv(); end
                else m_col++;
            end
        endcase
    endtask

    task automatic wait_ready();
        int n = 0;
        @(negedge CLK);
        while (bus.CHAR_READY !== 1'b1 && n < 5000) begin
            @(negedge CLK);
            n++;
        end
        checks++;
        assert (n < 5000) else begin
            errors++;
            $error("FAIL ready_timeout observed %0d cycles expected < 5000", n);
        end
    endtask

    task automatic send(logic [7:0] c, logic inv);
        model_char(c, inv);
        wait_ready();
        bus.CHAR_VALID = 1'b1;
        bus.CHAR_DATA  = c;
        bus.CHAR_INV   = inv;
        @(posedge CLK);
        #1;
        bus.CHAR_VALID = 1'b0;
    endtask

    task automatic check_cursor(string tag, int r, int c);
        wait_ready();
        checks++;
        assert (bus.CURSOR_ROW === 5'(r) && bus.CURSOR_COL === 7'(c)) else begin
            errors++;
            $error("FAIL %s observed (%0d,%0d) expected (%0d,%0d)", tag, bus.CURSOR_ROW, bus.CURSOR_COL, r, c);
        end
    endtask

    task automatic check_int(string tag, int obs, int exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp_v);
        end
    endtask

    task automatic measure_busy(output int cyc, output int rdy);
        int n = 0;
        cyc = 0;
        rdy = 0;
        @(negedge CLK);
        while (!bus.BUSY && n < 10) begin
            @(negedge CLK);
            n++;
        end
        while (bus.BUSY && cyc < 4000) begin
            cyc++;
            if (bus.CHAR_READY) rdy++;
            @(negedge CLK);
        end
    endtask

    task automatic check_idle_outputs(string tag);
        checks++;
        assert (bus.AVL_M_WRITE === 1'b0 && bus.AVL_M_READ === 1'b0 && bus.BUSY === 1'b0 &&
                bus.CHAR_READY === 1'b0 && bus.AVL_M_BYTE_EN === 4'd0 && bus.AVL_M_ADDR === 10'd0 &&
                bus.AVL_M_WRITEDATA === 32'd0 && bus.CURSOR_COL === 7'd0 && bus.CURSOR_ROW === 5'd0) else begin
            errors++;
            $error("FAIL %s observed wr=%0b rd=%0b busy=%0b rdy=%0b be=%b addr=%0d wd=%h cur=(%0d,%0d) expected all zero",
                   tag, bus.AVL_M_WRITE, bus.AVL_M_READ, bus.BUSY, bus.CHAR_READY, bus.AVL_M_BYTE_EN,
                   bus.AVL_M_ADDR, bus.AVL_M_WRITEDATA, bus.CURSOR_ROW, bus.CURSOR_COL);
        end
    endtask

    initial begin
        int cyc;
        int rdy;
        RESET          = 1'b1;
        fill_req       = 1'b0;
        bus.CHAR_VALID = 1'b0;
        bus.CHAR_DATA  = 8'h00;
        bus.CHAR_INV   = 1'b0;
        m_col          = 0;
        m_row          = 0;
        for (int i = 0; i < 600; i++) shadow[i] = 32'd0;

        repeat (3) @(negedge CLK);
        check_idle_outputs("reset_state");
        RESET = 1'b0;

        send(8'h41, 1'b0);
        check_cursor("put_A", 0, 1);

        for (int i = 0; i < 5; i++) send(8'h62 + 8'(i), 1'b0);
        check_cursor("col6", 0, 6);
        send(8'h48, 1'b1);
        check_cursor("put_inv", 0, 7);

        for (int i = 7; i < 79; i++) send(8'h61 + 8'(i % 26), 1'b0);
        check_cursor("col79", 0, 79);
        send(8'h78, 1'b0);
        check_cursor("wrap", 1, 0);

        send(8'h71, 1'b0);
        check_cursor("put_q", 1, 1);
        send(8'h08, 1'b0);
        check_cursor("bs", 1, 0);
        send(8'h08, 1'b0);
        check_cursor("bs_col0", 1, 0);
        send(8'h72, 1'b1);
        send(8'h0D, 1'b0);
        check_cursor("cr", 1, 0);

        wait_ready();
        fill_req = 1'b1;
        @(posedge CLK);
        #1;
        fill_req = 1'b0;
        for (int i = 0; i < 600; i++) shadow[i] = pat(i);

        for (int i = 0; i < 28; i++) send(8'h0A, 1'b0);
        check_cursor("lf_to_29", 29, 0);
        send(8'h0A, 1'b0);
        measure_busy(cyc, rdy);
        check_int("scroll_busy_cycles", cyc, 1760);
        check_cursor("after_scroll", 29, 0);
        check_int("scroll_queue_drained", exp_q.size(), 0);

        send(8'h0C, 1'b0);
        measure_busy(cyc, rdy);
        check_int("ff_busy_cycles", cyc, 600);
        check_int("ff_ready_during_busy", rdy, 0);
        check_cursor("after_ff", 0, 0);
        check_int("ff_queue_drained", exp_q.size(), 0);

        for (int i = 0; i < 29; i++) send(8'h0A, 1'b0);
        check_cursor("lf_to_29_again", 29, 0);
        send(8'h0A, 1'b0);
        repeat (100) @(posedge CLK);
        #3;
        RESET = 1'b1;
        #1;
        check_idle_outputs("reset_mid_scroll");
        exp_q.delete();
        m_col = 0;
        m_row = 0;
        @(negedge CLK);
        RESET = 1'b0;
        send(8'h5A, 1'b0);
        check_cursor("after_reset_put", 0, 1);
        check_int("final_queue_drained", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
